// File: rtl/t04_display_responder.sv
// rtl/t04_display_responder.sv - MMIO display register endpoint feeding an 8080-style parallel LCD write engine
module t04_display_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int          WR_LOW    = 2,
    parameter int          WR_HIGH   = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] display_address,
    input  logic [31:0] mem_store_display,
    input  logic        WEN,
    output logic        d_ack_display,
    output logic        lcd_cs_n,
    output logic        lcd_dc,
    output logic        lcd_wr_n,
    output logic [7:0]  lcd_data,
    output logic        lcd_busy
);

    localparam int CNT_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LO_LAST = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] HI_LAST = CW'(WR_HIGH - 1);

    typedef struct packed {
        logic        dc;
        logic        two_byte;
        logic [15:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WR_LO,
        S_WR_HI
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            pop, load_second;

    entry_t          fifo_mem [4];
    logic [1:0]      wr_ptr, rd_ptr;
    logic [2:0]      count;
    entry_t          push_entry;
    entry_t          head;

    logic            served;
    logic            mapped;
    logic            full;
    logic            accept;
    logic            push;
    logic [31:0]     offset;

    logic [7:0]      byte_q;
    logic [7:0]      low_q;
    logic            dc_q;
    logic            second_pending;

    logic            unused_data_hi;
    assign unused_data_hi = ^mem_store_display[31:16];

    // Only exact word offsets 0x0/0x4/0x8 inside the 16-byte window decode to a register.
    assign offset = display_address - BASE_ADDR;
    assign mapped = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00) && (offset[3:2] != 2'b11);
    assign full   = (count == 3'd4);
    assign accept = WEN && !served && (!mapped || !full);
    assign push   = accept && mapped;

    always_comb begin
        push_entry          = '0;
        push_entry.dc       = (offset[3:2] != 2'b00);
        push_entry.two_byte = (offset[3:2] == 2'b10);
        push_entry.data     = mem_store_display[15:0];
    end

    assign head = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            served        <= 1'b0;
            d_ack_display <= 1'b0;
        end else begin
            d_ack_display <= accept;
            if (accept) begin
                served <= 1'b1;
            end else if (!WEN) begin
                served <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A pop happens on the edge that enters SETUP, so the byte is on the bus for the whole SETUP cycle.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pop         = 1'b0;
        load_second = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != 3'd0) begin
                    state_next = S_SETUP;
                    pop        = 1'b1;
                end
            end
            S_SETUP: begin
                state_next = S_WR_LO;
                cnt_next   = '0;
            end
            S_WR_LO: begin
                if (cnt == LO_LAST) begin
                    state_next = S_WR_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_WR_HI: begin
                if (cnt == HI_LAST) begin
                    cnt_next = '0;
                    if (second_pending) begin
                        state_next  = S_SETUP;
                        load_second = 1'b1;
                    end else if (count != 3'd0) begin
                        state_next = S_SETUP;
                        pop        = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            byte_q         <= 8'h00;
            low_q          <= 8'h00;
            dc_q           <= 1'b0;
            second_pending <= 1'b0;
        end else if (pop) begin
            byte_q         <= head.two_byte ? head.data[15:8] : head.data[7:0];
            low_q          <= head.data[7:0];
            dc_q           <= head.dc;
            second_pending <= head.two_byte;
        end else if (load_second) begin
            byte_q         <= low_q;
            second_pending <= 1'b0;
        end
    end

    assign lcd_cs_n = (state == S_IDLE);
    assign lcd_wr_n = (state != S_WR_LO);
    assign lcd_dc   = dc_q;
    assign lcd_data = byte_q;
    assign lcd_busy = (count != 3'd0) || (state != S_IDLE);

endmodule

// File: tb/tb_t04_display_responder.sv
// tb/tb_t04_display_responder.sv - directed self-checking bench for t04_display_responder
module tb_t04_display_responder;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] display_address;
    logic [31:0] mem_store_display;
    logic        WEN;
    logic        d_ack_display;
    logic        lcd_cs_n;
    logic        lcd_dc;
    logic        lcd_wr_n;
    logic [7:0]  lcd_data;
    logic        lcd_busy;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int ac, lat, acks;
    int ack_at [6];
    logic [8:0] bytes_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LCD-side byte capture on the latching edge of the write strobe.
    always @(posedge lcd_wr_n) if (nrst === 1'b1) bytes_q.push_back({lcd_dc, lcd_data});

    t04_display_responder dut (
        .clk              (clk),
        .nrst             (nrst),
        .display_address  (display_address),
        .mem_store_display(mem_store_display),
        .WEN              (WEN),
        .d_ack_display    (d_ack_display),
        .lcd_cs_n         (lcd_cs_n),
        .lcd_dc           (lcd_dc),
        .lcd_wr_n         (lcd_wr_n),
        .lcd_data         (lcd_data),
        .lcd_busy         (lcd_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int ack_cyc, output int latency);
        @(negedge clk);
        display_address   = a;
        mem_store_display = d;
        WEN               = 1'b1;
        ack_cyc           = -1;
        latency           = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (d_ack_display === 1'b1) begin
                ack_cyc = cyc;
                latency = k;
                break;
            end
        end
        WEN = 1'b0;
        if (ack_cyc < 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (lcd_busy === 1'b0) return;
        end
        chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nrst              = 1'b0;
        WEN               = 1'b1;
        display_address   = 32'h0000_F000;
        mem_store_display = 32'h0000_0055;

        // Reset held with a pending request.
        repeat (3) @(negedge clk);
        chk("rst_ack",  32'(d_ack_display), 32'd0);
        chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
        chk("rst_dc",   32'(lcd_dc), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_busy", 32'(lcd_busy), 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        chk("rel_ack_hi", 32'(d_ack_display), 32'd1);
        WEN = 1'b0;
        @(negedge clk);
        chk("rel_ack_lo", 32'(d_ack_display), 32'd0);
        wait_idle();
        chk("rel_nbytes", bytes_q.size(), 32'd1);
        chk("rel_byte", 32'(bytes_q[0]), 32'h055);

        // CMD write: SETUP, two low cycles, two high cycles, then chip select released.
        bytes_q.delete();
        do_write(32'h0000_F000, 32'h0000_002A, ac, lat);
        chk("cmd_lat", lat, 32'd1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) chk("cmd_ack_pulse", 32'(d_ack_display), 32'd0);
            chk($sformatf("cmd_cs_n[%0d]", i), 32'(lcd_cs_n), (i == 6) ? 32'd1 : 32'd0);
            chk($sformatf("cmd_wr_n[%0d]", i), 32'(lcd_wr_n), (i == 2 || i == 3) ? 32'd0 : 32'd1);
            if (i <= 5) begin
                chk($sformatf("cmd_data[%0d]", i), 32'(lcd_data), 32'h2A);
                chk($sformatf("cmd_dc[%0d]", i), 32'(lcd_dc), 32'd0);
            end
        end
        chk("cmd_busy_end", 32'(lcd_busy), 32'd0);
        chk("cmd_nbytes", bytes_q.size(), 32'd1);
        chk("cmd_byte", 32'(bytes_q[0]), 32'h02A);

        // DATA16: high byte then low byte, chip select low for 10 cycles.
        bytes_q.delete();
        do_write(32'h0000_F008, 32'h1234_ABCD, ac, lat);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            chk($sformatf("d16_cs_n[%0d]", i), 32'(lcd_cs_n), (i == 11) ? 32'd1 : 32'd0);
            chk($sformatf("d16_wr_n[%0d]", i), 32'(lcd_wr_n),
                (i <= 10 && ((i - 1) % 5 == 1 || (i - 1) % 5 == 2)) ? 32'd0 : 32'd1);
            if (i <= 10) begin
                chk($sformatf("d16_data[%0d]", i), 32'(lcd_data), (i <= 5) ? 32'hAB : 32'hCD);
                chk($sformatf("d16_dc[%0d]", i), 32'(lcd_dc), 32'd1);
            end
        end
        chk("d16_nbytes", bytes_q.size(), 32'd2);
        chk("d16_b0", 32'(bytes_q[0]), 32'h1AB);
        chk("d16_b1", 32'(bytes_q[1]), 32'h1CD);

        // WEN held for 20 cycles is captured only once.
        bytes_q.delete();
        @(negedge clk);
        display_address   = 32'h0000_F004;
        mem_store_display = 32'h0000_0077;
        WEN               = 1'b1;
        acks              = 0;
        repeat (20) begin
            @(negedge clk);
            if (d_ack_display === 1'b1) acks++;
        end
        WEN = 1'b0;
        chk("held_acks", acks, 32'd1);
        wait_idle();
        chk("held_nbytes", bytes_q.size(), 32'd1);
        chk("held_byte", 32'(bytes_q[0]), 32'h177);

        // Six back-to-back DATA8 writes come out in order.
        bytes_q.delete();
        for (int i = 1; i <= 6; i++) do_write(32'h0000_F004, 32'(i), ac, lat);
        wait_idle();
        chk("d8_nbytes", bytes_q.size(), 32'd6);
        for (int i = 1; i <= 6; i++) chk($sformatf("d8_byte[%0d]", i), 32'(bytes_q[i-1]), 32'h100 + 32'(i));

        // Six DATA16 writes fill the FIFO: the 6th waits for a pop and is not accepted on the pop edge itself.
        bytes_q.delete();
        for (int i = 0; i < 6; i++) begin
            do_write(32'h0000_F008, {16'h0, 8'(8'h10 + i), 8'(8'h20 + i)}, ac, lat);
            ack_at[i] = ac;
        end
        for (int i = 1; i < 6; i++)
            chk($sformatf("bp_ack_gap[%0d]", i), 32'(ack_at[i] - ack_at[i-1]), (i == 5) ? 32'd4 : 32'd2);
        wait_idle();
        chk("bp_nbytes", bytes_q.size(), 32'd12);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_hi[%0d]", i), 32'(bytes_q[2*i]),   32'h110 + 32'(i));
            chk($sformatf("bp_lo[%0d]", i), 32'(bytes_q[2*i+1]), 32'h120 + 32'(i));
        end

        // Unmapped addresses are acked and discarded.
        bytes_q.delete();
        do_write(32'h0000_F00C, 32'h0000_00EE, ac, lat);
        chk("unmap_c_lat", lat, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("unmap_c_cs_n", 32'(lcd_cs_n), 32'd1);
            chk("unmap_c_busy", 32'(lcd_busy), 32'd0);
        end
        do_write(32'h0000_0100, 32'h0000_00EF, ac, lat);
        chk("unmap_o_lat", lat, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("unmap_o_cs_n", 32'(lcd_cs_n), 32'd1);
            chk("unmap_o_busy", 32'(lcd_busy), 32'd0);
        end
        chk("unmap_nbytes", bytes_q.size(), 32'd0);

        // Asynchronous reset in the middle of a strobe low phase.
        do_write(32'h0000_F008, 32'h0000_BEEF, ac, lat);
        repeat (3) @(negedge clk);
        chk("mid_wr_low", 32'(lcd_wr_n), 32'd0);
        #2 nrst = 1'b0;
        #1;
        chk("mid_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("mid_wr_n", 32'(lcd_wr_n), 32'd1);
        chk("mid_busy", 32'(lcd_busy), 32'd0);
        chk("mid_data", 32'(lcd_data), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("post_busy", 32'(lcd_busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
